control_input_decoder: RTL and testbench
========================================

Name: control_input_decoder

Overview:
- Front-end input block for the scaler datapath. Debounces the four algorithm-select switches and the two zoom pushbuttons.
- Derives the algorithm code, the switch-error flags and the invalid-zoom flag consumed by the 7-segment message display.
- Maintains the current zoom exponent and issues a one-cycle start request to the scaler, with a busy handshake and a pending-restart buffer.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a synchronized input is accepted. Minimum 2.
- MAX_ZOOM_IN, 2: maximum positive zoom exponent (2^+N scaling).
- MAX_ZOOM_OUT, 2: maximum negative exponent magnitude (2^-N scaling).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- sw  input  4  raw algorithm switches: sw[0] nearest neighbor, sw[1] pixel replication, sw[2] decimation, sw[3] block averaging
- key_zoom_in_n  input  1  raw pushbutton, active-low
- key_zoom_out_n  input  1  raw pushbutton, active-low
- scaler_busy  input  1  scaler processing, high while busy
- algorithm_select  output  2  encoded algorithm (00/01/10/11, same order as sw)
- no_switch_selected_error  output  1  debounced sw == 0
- multiple_switches_error  output  1  more than one debounced sw bit set
- invalid_zoom_error  output  1  last zoom request was rejected
- zoom_exp  output  3  signed two's-complement zoom exponent
- scale_start  output  1  one-cycle request to scaler

Behaviour:
- Reset: clk and reset are as already decided; reset is asynchronous, active-high, clock is clk. During reset all outputs are 0 (algorithm_select=00, zoom_exp=0, errors=0, scale_start=0). Debounced sw=0, debounced keys=1 (released), pending=0.
- Synchronization: every raw input passes through a 2-FF synchronizer.
- Debounce, per bit:
  - A counter increments while the synchronized value differs from the stable value and clears when they are equal.
  - On DEBOUNCE_CYCLES consecutive differing cycles, stable takes the synchronized value.
- Press events: a press event is a one-cycle pulse on a stable 1->0 transition of a key.
- Error flags: registered, one cycle after the debounced sw change.
  - no_switch_selected_error = (sw_stable == 0).
  - multiple_switches_error = popcount(sw_stable) >= 2.
  - After reset release, no_switch_selected_error rises 1 cycle later if no switch is held.
- algorithm_select: updates only when exactly one sw_stable bit is set; otherwise it holds its last value.
- Algorithm change: when algorithm_select takes a new value, zoom_exp <= 0, invalid_zoom_error <= 0 and a restart is requested.
- Zoom classes: codes 00/01 are zoom-in algorithms (legal exp 0..+MAX_ZOOM_IN); codes 10/11 are zoom-out algorithms (legal exp -MAX_ZOOM_OUT..0).
- Zoom-in press: accepted if the result exp+1 is within the legal range for the current class; zoom_exp <= exp+1. Otherwise rejected: invalid_zoom_error <= 1 and zoom_exp unchanged.
- Zoom-out press: symmetric, using exp-1.
- Press filtering:
  - Presses are ignored (no state change, no flag) while either switch error is active.
  - Presses are ignored while scaler_busy=1 or pending=1.
  - Simultaneous in+out press events in the same cycle are both ignored.
- invalid_zoom_error clearing: sticky. Cleared by the next accepted press, by an algorithm change, or by either switch error becoming active.
- Restart handshake:
  - Sources: an accepted press, an algorithm change, or a falling edge of a switch error that leaves a single valid switch.
  - If scaler_busy=0, scale_start pulses 1 cycle in the same cycle zoom_exp/algorithm_select are updated.
  - If scaler_busy=1, pending <= 1.
  - When pending=1 and scaler_busy=0, scale_start pulses for 1 cycle and pending clears.
  - Multiple requests while pending merge into one.
  - No scale_start is issued while a switch error is active; pending is held until the error clears.
- Latency:
  - Raw change to debounced value: 2 + DEBOUNCE_CYCLES cycles.
  - Debounced key edge to zoom_exp/scale_start: 1 cycle after the press pulse.
- Reset mid-operation: everything returns to reset values immediately; debouncers restart.
- zoom_exp never leaves the legal range for the current class.

Test Plan:
(DEBOUNCE_CYCLES=4, MAX_ZOOM_IN=2, MAX_ZOOM_OUT=2)
1. sw=0001 held, reset released -> algorithm_select=00, no_switch_selected_error=1 until the debounce completes, then 0. scale_start pulses once, zoom_exp=0.
2. sw=0001, three zoom-in presses, busy=0 -> zoom_exp 1, 2, then third rejected: invalid_zoom_error=1, zoom_exp=2. A following zoom-out gives zoom_exp=1 and invalid_zoom_error=0.
3. sw=0100, zoom-in press at exp=0 -> invalid_zoom_error=1. Two zoom-outs -> zoom_exp=-2 (3'b110).
4. sw glitch 0001->0011 for 3 cycles -> no change in any output. Held 0011 -> multiple_switches_error=1, presses ignored, algorithm_select holds 00.
5. scaler_busy=1, switch change 0001->1000 -> algorithm_select=11, zoom_exp=0, no scale_start. busy falls -> exactly one scale_start pulse.
6. Assert reset mid-debounce with zoom_exp=2 and pending=1 -> all outputs 0 and pending cleared within the reset assertion.

Source files
------------

// File: rtl/control_input_decoder.sv
// rtl/control_input_decoder.sv - debounced switch/key front end with zoom state and scaler start handshake
module control_input_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_ZOOM_IN     = 2,
  parameter int MAX_ZOOM_OUT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       key_zoom_in_n,
  input  logic       key_zoom_out_n,
  input  logic       scaler_busy,
  output logic [1:0] algorithm_select,
  output logic       no_switch_selected_error,
  output logic       multiple_switches_error,
  output logic       invalid_zoom_error,
  output logic [2:0] zoom_exp,
  output logic       scale_start
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [5:0] RAW_RST = 6'b110000;  // keys idle high, switches low
  localparam logic signed [3:0] ZOOM_HI = 4'(MAX_ZOOM_IN);
  localparam logic signed [3:0] ZOOM_LO = 4'(-MAX_ZOOM_OUT);

  logic [5:0] sync1_q, sync2_q, stable_q, stable_d;
  logic [5:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0] key_prev_q, key_prev_d;
  logic [1:0] alg_q, alg_d;
  logic       no_sw_q, no_sw_d, multi_q, multi_d;
  logic       inv_q, inv_d, start_q, start_d, pending_q, pending_d;
  logic [2:0] zexp_q, zexp_d;

  logic [3:0] sw_s;
  logic [2:0] ones;
  logic [1:0] code;
  logic       press_in, press_out, press_ok, err_q, err_d;
  logic       alg_change, err_fall, err_rise, restart;
  logic signed [3:0] exp_s, exp_inc, exp_dec, lim_hi, lim_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= RAW_RST;
      sync2_q    <= RAW_RST;
      stable_q   <= RAW_RST;
      cnt_q      <= '0;
      key_prev_q <= 2'b11;
      alg_q      <= 2'b00;
      no_sw_q    <= 1'b0;
      multi_q    <= 1'b0;
      inv_q      <= 1'b0;
      start_q    <= 1'b0;
      pending_q  <= 1'b0;
      zexp_q     <= 3'b000;
    end else begin
      sync1_q    <= {key_zoom_out_n, key_zoom_in_n, sw};
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      key_prev_q <= key_prev_d;
      alg_q      <= alg_d;
      no_sw_q    <= no_sw_d;
      multi_q    <= multi_d;
      inv_q      <= inv_d;
      start_q    <= start_d;
      pending_q  <= pending_d;
      zexp_q     <= zexp_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign sw_s       = stable_q[3:0];
  assign ones       = 3'(sw_s[0]) + 3'(sw_s[1]) + 3'(sw_s[2]) + 3'(sw_s[3]);
  assign key_prev_d = stable_q[5:4];
  assign press_in   = key_prev_q[0] & ~stable_q[4];
  assign press_out  = key_prev_q[1] & ~stable_q[5];

  always_comb begin
    code = alg_q;
    case (sw_s)
      4'b0001: code = 2'b00;
      4'b0010: code = 2'b01;
      4'b0100: code = 2'b10;
      4'b1000: code = 2'b11;
      default: code = alg_q;
    endcase
  end

  // Error state seen after this edge decides gating, so a clearing error can restart at once
  assign no_sw_d    = (ones == 3'd0);
  assign multi_d    = (ones >= 3'd2);
  assign err_q      = no_sw_q | multi_q;
  assign err_d      = no_sw_d | multi_d;
  assign err_fall   = err_q & ~err_d;
  assign err_rise   = ~err_q & err_d;
  assign alg_change = (ones == 3'd1) & (code != alg_q);
  assign press_ok   = ~err_q & ~err_d & ~scaler_busy & ~pending_q & (press_in ^ press_out);

  assign exp_s   = {zexp_q[2], zexp_q};
  assign exp_inc = exp_s + 4'sd1;
  assign exp_dec = exp_s - 4'sd1;
  assign lim_hi  = alg_q[1] ? 4'sd0 : ZOOM_HI;
  assign lim_lo  = alg_q[1] ? ZOOM_LO : 4'sd0;

  always_comb begin
    alg_d     = alg_q;
    zexp_d    = zexp_q;
    inv_d     = inv_q;
    pending_d = pending_q;
    start_d   = 1'b0;
    restart   = 1'b0;
    if (alg_change) begin
      alg_d   = code;
      zexp_d  = 3'b000;
      inv_d   = 1'b0;
      restart = 1'b1;
    end else if (press_ok) begin
      if (press_in) begin
        if (exp_inc <= lim_hi) begin
          zexp_d  = exp_inc[2:0];
          inv_d   = 1'b0;
          restart = 1'b1;
        end else begin
          inv_d = 1'b1;
        end
      end else begin
        if (exp_dec >= lim_lo) begin
          zexp_d  = exp_dec[2:0];
          inv_d   = 1'b0;
          restart = 1'b1;
        end else begin
          inv_d = 1'b1;
        end
      end
    end
    if (err_rise) inv_d = 1'b0;
    if (err_fall) restart = 1'b1;
    if (err_d || scaler_busy) begin
      pending_d = pending_q | restart;
    end else begin
      start_d   = restart | pending_q;
      pending_d = 1'b0;
    end
  end

  assign algorithm_select         = alg_q;
  assign no_switch_selected_error = no_sw_q;
  assign multiple_switches_error  = multi_q;
  assign invalid_zoom_error       = inv_q;
  assign zoom_exp                 = zexp_q;
  assign scale_start              = start_q;

endmodule

// File: tb/tb_control_input_decoder.sv
// tb/tb_control_input_decoder.sv - directed scoreboard bench for control_input_decoder
module tb_control_input_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       key_zoom_in_n, key_zoom_out_n, scaler_busy;
  logic [1:0] algorithm_select;
  logic       no_switch_selected_error, multiple_switches_error, invalid_zoom_error;
  logic [2:0] zoom_exp;
  logic       scale_start;

  control_input_decoder #(
    .DEBOUNCE_CYCLES(4),
    .MAX_ZOOM_IN(2),
    .MAX_ZOOM_OUT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .key_zoom_in_n(key_zoom_in_n),
    .key_zoom_out_n(key_zoom_out_n),
    .scaler_busy(scaler_busy),
    .algorithm_select(algorithm_select),
    .no_switch_selected_error(no_switch_selected_error),
    .multiple_switches_error(multiple_switches_error),
    .invalid_zoom_error(invalid_zoom_error),
    .zoom_exp(zoom_exp),
    .scale_start(scale_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] alg;
    logic       ns;
    logic       ms;
    logic       inv;
    logic [2:0] zexp;
    int         starts;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int exp_starts = 0;
  int start_cnt = 0;

  // Count start pulses a little after each rising edge, well away from the negedge checks
  always @(posedge clk) begin
    #2;
    if (scale_start === 1'b1) start_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic expect_state(input string tag, input logic [1:0] a, input logic ns, input logic ms,
                              input logic inv, input logic [2:0] z);
    exp_t e;
    e.tag = tag; e.alg = a; e.ns = ns; e.ms = ms; e.inv = inv; e.zexp = z; e.starts = exp_starts;
    sb.push_back(e);
  endtask

  task automatic check_state();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "alg", 32'(algorithm_select), 32'(e.alg));
    chk(e.tag, "no_sw", 32'(no_switch_selected_error), 32'(e.ns));
    chk(e.tag, "multi", 32'(multiple_switches_error), 32'(e.ms));
    chk(e.tag, "inv", 32'(invalid_zoom_error), 32'(e.inv));
    chk(e.tag, "zexp", 32'(zoom_exp), 32'(e.zexp));
    chk(e.tag, "starts", 32'(start_cnt), 32'(e.starts));
  endtask

  task automatic press_in();
    key_zoom_in_n = 1'b0; wait_n(10);
    key_zoom_in_n = 1'b1; wait_n(10);
  endtask

  task automatic press_out();
    key_zoom_out_n = 1'b0; wait_n(10);
    key_zoom_out_n = 1'b1; wait_n(10);
  endtask

  initial begin
    reset = 1'b1; sw = 4'b0001; key_zoom_in_n = 1'b1; key_zoom_out_n = 1'b1; scaler_busy = 1'b0;
    wait_n(3);
    expect_state("in_reset", 2'b00, 0, 0, 0, 3'b000); check_state();

    // 1: reset release with one switch held
    reset = 1'b0; wait_n(1);
    expect_state("post_reset", 2'b00, 1, 0, 0, 3'b000); check_state();
    exp_starts = 1; wait_n(12);
    expect_state("t1_settled", 2'b00, 0, 0, 0, 3'b000); check_state();

    // 2: zoom-in class up to +2, then reject, then step back
    press_in();  exp_starts = 2; expect_state("t2_in1", 2'b00, 0, 0, 0, 3'b001); check_state();
    press_in();  exp_starts = 3; expect_state("t2_in2", 2'b00, 0, 0, 0, 3'b010); check_state();
    press_in();  expect_state("t2_in3_rej", 2'b00, 0, 0, 1, 3'b010); check_state();
    press_out(); exp_starts = 4; expect_state("t2_out", 2'b00, 0, 0, 0, 3'b001); check_state();

    // 3: decimation class
    sw = 4'b0100; wait_n(12); exp_starts = 5;
    expect_state("t3_alg", 2'b10, 0, 0, 0, 3'b000); check_state();
    press_in();  expect_state("t3_in_rej", 2'b10, 0, 0, 1, 3'b000); check_state();
    press_out(); exp_starts = 6; expect_state("t3_out1", 2'b10, 0, 0, 0, 3'b111); check_state();
    press_out(); exp_starts = 7; expect_state("t3_out2", 2'b10, 0, 0, 0, 3'b110); check_state();
    press_out(); expect_state("t3_out3_rej", 2'b10, 0, 0, 1, 3'b110); check_state();

    // 4: glitch rejection and multiple-switch error
    sw = 4'b0001; wait_n(12); exp_starts = 8;
    expect_state("t4_back", 2'b00, 0, 0, 0, 3'b000); check_state();
    sw = 4'b0011; wait_n(3); sw = 4'b0001; wait_n(12);
    expect_state("t4_glitch", 2'b00, 0, 0, 0, 3'b000); check_state();
    sw = 4'b0011; wait_n(12);
    expect_state("t4_multi", 2'b00, 0, 1, 0, 3'b000); check_state();
    press_in();  expect_state("t4_press_ign", 2'b00, 0, 1, 0, 3'b000); check_state();
    sw = 4'b0001; wait_n(12); exp_starts = 9;
    expect_state("t4_err_clear", 2'b00, 0, 0, 0, 3'b000); check_state();

    // 5: algorithm change while busy defers the start
    scaler_busy = 1'b1; sw = 4'b1000; wait_n(12);
    expect_state("t5_busy_alg", 2'b11, 0, 0, 0, 3'b000); check_state();
    press_out(); expect_state("t5_busy_press", 2'b11, 0, 0, 0, 3'b000); check_state();
    scaler_busy = 1'b0; wait_n(3); exp_starts = 10;
    expect_state("t5_release", 2'b11, 0, 0, 0, 3'b000); check_state();
    wait_n(10);
    expect_state("t5_once", 2'b11, 0, 0, 0, 3'b000); check_state();

    // 6: reset mid-debounce with exp=2 and a pending restart
    sw = 4'b0001; wait_n(12); exp_starts = 11;
    press_in(); press_in(); exp_starts = 13;
    expect_state("t6_exp2", 2'b00, 0, 0, 0, 3'b010); check_state();
    scaler_busy = 1'b1; sw = 4'b0011; wait_n(12);
    expect_state("t6_multi", 2'b00, 0, 1, 0, 3'b010); check_state();
    sw = 4'b0001; wait_n(12);
    expect_state("t6_pending", 2'b00, 0, 0, 0, 3'b010); check_state();
    chk("t6_pending", "pending", 32'(dut.pending_q), 32'd1);
    sw = 4'b0100; wait_n(3);
    reset = 1'b1; wait_n(1);
    expect_state("t6_reset", 2'b00, 0, 0, 0, 3'b000); check_state();
    chk("t6_reset", "pending", 32'(dut.pending_q), 32'd0);
    scaler_busy = 1'b0; wait_n(2); reset = 1'b0; wait_n(14); exp_starts = 14;
    expect_state("t6_after", 2'b10, 0, 0, 0, 3'b000); check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
